// File: rtl/uart_tx_serial_if.sv
// uart_tx_serial_if: byte handshake between the transmit FIFO and the UART transmitter
interface uart_tx_serial_if;
    logic       order;
    logic [7:0] data;
    logic       sendable;
    modport master(output order, output data, input sendable);
    modport slave(input order, input data, output sendable);
endinterface

// File: rtl/uart_tx_serial.sv
// uart_tx_serial: 8N1 UART transmitter with a one-byte holding register for gapless frames
`ifndef DEFAULT_BAUD
`define DEFAULT_BAUD 16
`endif
module uart_tx_serial #(
    parameter int BAUD = `DEFAULT_BAUD
) (
    input  logic            clk,
    input  logic            rstn,
    uart_tx_serial_if.slave bus,
    output logic            txd
);
    localparam int CW = $clog2(BAUD);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift, shift_n, hold, hold_n;
    logic          hold_v, hold_v_n, txd_n;
    logic          accept, avail, bit_end, load;
    assign accept       = bus.order & ~hold_v;
    assign avail        = hold_v | accept;
    assign bit_end      = cnt == CW'(BAUD - 1);
    assign bus.sendable = ~hold_v;
    always_comb begin
        state_n   = state;
        cnt_n     = bit_end ? '0 : cnt + 1'b1;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        load      = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (avail) begin
                    state_n = START;
                    load    = 1'b1;
                end
            end
            START: if (bit_end) begin
                state_n   = DATA;
                bit_idx_n = '0;
            end
            DATA: if (bit_end) begin
                shift_n   = shift >> 1;
                bit_idx_n = bit_idx + 1'b1;
                if (bit_idx == 3'd7) state_n = STOP;
            end
            STOP: if (bit_end) begin
                state_n = avail ? START : IDLE;
                load    = avail;
            end
            default: state_n = IDLE;
        endcase
        // a load drains hold if it is full, otherwise the accepted byte bypasses it
        if (load) shift_n = hold_v ? hold : bus.data;
        hold_v_n = avail & ~load;
        hold_n   = (accept & ~load) ? bus.data : hold;
        txd_n    = (state_n == START) ? 1'b0 : (state_n == DATA) ? shift_n[0] : 1'b1;
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            hold    <= '0;
            hold_v  <= 1'b0;
            txd     <= 1'b1;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
            hold    <= hold_n;
            hold_v  <= hold_v_n;
            txd     <= txd_n;
        end
    end
endmodule

// File: tb/tb_uart_tx_serial.sv
// tb_uart_tx_serial: scoreboard bench; a schedule model predicts frame start times and sendable,
// a line receiver decodes every frame and checks it against the expected queue
module tb_uart_tx_serial;
    localparam int B  = 4;
    localparam int BM = 2;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic txd, txd_m;
    uart_tx_serial_if bus();
    uart_tx_serial_if bus_m();
    uart_tx_serial #(.BAUD(B)) dut (.clk(clk), .rstn(rstn), .bus(bus.slave), .txd(txd));
    uart_tx_serial #(.BAUD(BM)) dut_m (.clk(clk), .rstn(rstn), .bus(bus_m.slave), .txd(txd_m));
    always #5 clk = ~clk;

    typedef struct {
        int         start;
        logic [7:0] d;
    } exp_t;
    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   last_start = -1000;
    logic rst_q = 1'b0;

    function automatic logic frame_bit(logic [7:0] d, int k);
        return (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : d[k-1];
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // schedule model: a frame starts at its accept edge, or when the previous frame's 10 bit periods end
    always @(posedge clk) begin
        int   s;
        exp_t e;
        if (!rstn) begin
            exp_q.delete();
            last_start <= -1000;
        end else if (bus.order && last_start <= cyc) begin
            s = (cyc + 1 > last_start + 10 * B) ? cyc + 1 : last_start + 10 * B;
            e.start = s;
            e.d = bus.data;
            exp_q.push_back(e);
            last_start <= s;
        end
        rst_q <= !rstn;
        cyc <= cyc + 1;
    end

    logic [10*B-1:0] samp;
    bit              in_frame = 1'b0;
    int              pos, fstart;

    task automatic check_frame();
        logic [7:0] d;
        bit         shape_ok = 1'b1;
        exp_t       e;
        for (int k = 0; k < 10; k++)
            for (int j = 0; j < B; j++)
                if (samp[k*B+j] !== samp[k*B]) shape_ok = 1'b0;
        for (int i = 0; i < 8; i++) d[i] = samp[(i+1)*B];
        chk("frame_shape", {31'd0, shape_ok && samp[9*B] === 1'b1}, 32'd1);
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_frame: got byte %0h starting cycle %0d, expected no frame", d, fstart);
        end else begin
            e = exp_q.pop_front();
            chk("frame_data", {24'd0, d}, {24'd0, e.d});
            chk("frame_start", fstart, e.start);
        end
    endtask

    always @(negedge clk) begin
        if (cyc > 0) begin
            if (rst_q) begin
                in_frame = 1'b0;
                chk("reset_txd", {31'd0, txd}, 32'd1);
                chk("reset_sendable", {31'd0, bus.sendable}, 32'd1);
            end else begin
                chk("sendable", {31'd0, bus.sendable}, {31'd0, last_start <= cyc});
                if (!in_frame && txd !== 1'b1) begin
                    in_frame = 1'b1;
                    pos = 0;
                    fstart = cyc;
                end
                if (in_frame) begin
                    samp[pos] = txd;
                    pos++;
                    if (pos == 10 * B) begin
                        check_frame();
                        in_frame = 1'b0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(logic [7:0] d, bit keep);
        bit acc;
        bus.order = 1'b1;
        bus.data = d;
        for (int i = 0; i < 200; i++) begin
            acc = last_start <= cyc;
            tick();
            if (acc) begin
                if (!keep) bus.order = 1'b0;
                return;
            end
        end
        vectors++;
        miscompares++;
        $display("FAIL send_timeout: byte %0h not accepted within 200 cycles", d);
        bus.order = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && (exp_q.size() != 0 || in_frame); i++) tick();
        chk("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic prev;
        int   tr, s81;
        bus.order = 1'b0;
        bus.data = '0;
        bus_m.order = 1'b0;
        bus_m.data = '0;
        rstn = 1'b0;
        repeat (3) tick();
        rstn = 1'b1;
        prev = txd;
        tr = 0;
        repeat (50) begin
            tick();
            if (txd !== prev) tr++;
            prev = txd;
        end
        chk("idle_transitions", tr, 0);
        chk("idle_txd", {31'd0, txd}, 32'd1);
        chk("idle_sendable", {31'd0, bus.sendable}, 32'd1);

        chk("min_idle_txd", {31'd0, txd_m}, 32'd1);
        bus_m.order = 1'b1;
        bus_m.data = 8'h55;
        tick();
        bus_m.order = 1'b0;
        for (int t = 0; t < 10 * BM; t++) begin
            chk("min_bit", {31'd0, txd_m}, {31'd0, frame_bit(8'h55, t / BM)});
            chk("min_sendable", {31'd0, bus_m.sendable}, 32'd1);
            tick();
        end
        chk("min_frame_end", {31'd0, txd_m}, 32'd1);

        send(8'hA5, 1'b0);
        drain();

        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        send(8'h3C, 1'b0);
        drain();

        for (int i = 0; i < 400; i++) begin
            bus.order = $urandom_range(0, 3) != 0;
            bus.data = 8'($urandom);
            if ($urandom_range(0, 40) == 0) begin
                bus.order = 1'b0;
                repeat ($urandom_range(10, 60)) tick();
            end
            tick();
        end
        bus.order = 1'b0;
        drain();

        send(8'h81, 1'b0);
        s81 = last_start;
        send(8'h7E, 1'b0);
        for (int i = 0; i < 100 && cyc < s81 + 15; i++) tick();
        chk("midreset_hold_full", {31'd0, bus.sendable}, 32'd0);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("midreset_txd", {31'd0, txd}, 32'd1);
        chk("midreset_sendable", {31'd0, bus.sendable}, 32'd1);
        repeat (60) tick();
        send(8'h42, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
